// File: rtl/odd_even_step_counter.sv
// Parity-locked up/down counter with programmable even step, sync load,
// wrap-or-saturate ends, a registered terminal-count pulse and a saturating wrap counter.
module odd_even_step_counter #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 2,
  parameter int SATURATE = 0,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_ALIGN,
    ACT_STEP
  } act_e;

  act_e              act;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              tc_q, tc_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              par;
  logic [WIDTH:0]    max_x, min_x, sum_x;
  logic              ovf, unf, edge_hit;

  always_comb begin
    par      = ~mode;
    max_x    = {1'b0, {(WIDTH-1){1'b1}}, par};
    min_x    = {{WIDTH{1'b0}}, par};
    // Bounds are evaluated one bit wider so the up-step carry is visible.
    sum_x    = {1'b0, count_q} + STEP_X;
    ovf      = ~dir && (sum_x > max_x);
    unf      = dir && ({1'b0, count_q} < (min_x + STEP_X));
    edge_hit = ovf || unf;

    if (load)                     act = ACT_LOAD;
    else if (en && count_q[0] != par) act = ACT_ALIGN;
    else if (en)                  act = ACT_STEP;
    else                          act = ACT_HOLD;
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    wrap_d  = wrap_q;
    unique case (act)
      ACT_LOAD:  count_d = {load_val[WIDTH-1:1], par};
      ACT_ALIGN: count_d = {count_q[WIDTH-1:1], par};
      ACT_STEP: begin
        if ((SATURATE != 0) && edge_hit) begin
          count_d = ovf ? max_x[WIDTH-1:0] : min_x[WIDTH-1:0];
          tc_d    = 1'b1;
        end else begin
          count_d = dir ? (count_q - STEP_N) : sum_x[WIDTH-1:0];
          tc_d    = edge_hit;
          if (edge_hit && (wrap_q != '1)) wrap_d = wrap_q + WRAP_W'(1);
        end
      end
      ACT_HOLD:  count_d = count_q;
      default:   count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= WIDTH'(1);
      tc_q    <= 1'b0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_odd_even_step_counter.sv
// Directed bench for odd_even_step_counter: default, STEP=6 and SATURATE=1
// instances share one stimulus stream; each check targets the relevant instance.
module tb_odd_even_step_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, mode, dir, load;
  logic [7:0] load_val;

  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic [7:0] wr_a, wr_b, wr_c;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  odd_even_step_counter #(.WIDTH(8), .STEP(2), .SATURATE(0), .WRAP_W(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .count(cnt_a), .tc(tc_a), .wrap_cnt(wr_a)
  );

  odd_even_step_counter #(.WIDTH(8), .STEP(6), .SATURATE(0), .WRAP_W(8)) u_dut_s6 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .count(cnt_b), .tc(tc_b), .wrap_cnt(wr_b)
  );

  odd_even_step_counter #(.WIDTH(8), .STEP(2), .SATURATE(1), .WRAP_W(8)) u_dut_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .count(cnt_c), .tc(tc_c), .wrap_cnt(wr_c)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    #12;
    chk("rst_count", cnt_a, 1);
    chk("rst_tc", tc_a, 0);
    chk("rst_wrap", wr_a, 0);

    // 1: odd up-count through the wrap
    reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 127; k++) begin
      tick();
      chk("t1_count", cnt_a, 1 + 2 * k);
      chk("t1_tc", tc_a, 0);
    end
    chk("t1_wrap_pre", wr_a, 0);
    tick();
    chk("t1_wrap_count", cnt_a, 1);
    chk("t1_wrap_tc", tc_a, 1);
    chk("t1_wrap_cnt", wr_a, 1);
    tick();
    chk("t1_after_count", cnt_a, 3);
    chk("t1_after_tc", tc_a, 0);

    // 2: even mode alignment, then back to odd
    do_reset();
    mode = 1'b1;
    tick();
    chk("t2_align", cnt_a, 0);
    chk("t2_align_tc", tc_a, 0);
    tick(); chk("t2_e2", cnt_a, 2);
    tick(); chk("t2_e4", cnt_a, 4);
    tick(); chk("t2_e6", cnt_a, 6);
    mode = 1'b0;
    tick(); chk("t2_o7", cnt_a, 7);
    chk("t2_o7_tc", tc_a, 0);
    tick(); chk("t2_o9", cnt_a, 9);

    // 3: down-count underflow, STEP=2 then STEP=6
    load = 1'b1; load_val = 8'h00; dir = 1'b1;
    tick();
    chk("t3_load1", cnt_a, 1);
    load = 1'b0;
    tick();
    chk("t3_dn_count", cnt_a, 255);
    chk("t3_dn_tc", tc_a, 1);
    chk("t3_dn_wrap", wr_a, 1);
    tick();
    chk("t3_dn2_count", cnt_a, 253);
    chk("t3_dn2_tc", tc_a, 0);
    load = 1'b1; load_val = 8'h02;
    tick();
    chk("t3_s6_load", cnt_b, 3);
    load = 1'b0;
    tick();
    chk("t3_s6_count", cnt_b, 253);
    chk("t3_s6_tc", tc_b, 1);

    // 4: load priority over enable, and load without enable
    dir = 1'b0; load = 1'b1; load_val = 8'h10;
    tick();
    chk("t4_load", cnt_a, 8'h11);
    chk("t4_load_tc", tc_a, 0);
    load = 1'b0;
    tick();
    chk("t4_step", cnt_a, 8'h13);
    en = 1'b0; load = 1'b1; load_val = 8'h20;
    tick();
    chk("t4_load_noen", cnt_a, 8'h21);
    load = 1'b0;
    tick();
    chk("t4_hold", cnt_a, 8'h21);
    chk("t4_hold_tc", tc_a, 0);

    // 5: saturating instance clamps at both ends
    load = 1'b1; load_val = 8'hFD;
    tick();
    chk("t5_load", cnt_c, 253);
    load = 1'b0; en = 1'b1;
    tick();
    chk("t5_255", cnt_c, 255);
    chk("t5_255_tc", tc_c, 0);
    tick();
    chk("t5_clamp1", cnt_c, 255);
    chk("t5_clamp1_tc", tc_c, 1);
    tick();
    chk("t5_clamp2", cnt_c, 255);
    chk("t5_clamp2_tc", tc_c, 1);
    en = 1'b0;
    tick();
    chk("t5_dis", cnt_c, 255);
    chk("t5_dis_tc", tc_c, 0);
    chk("t5_wrap", wr_c, 0);
    load = 1'b1; load_val = 8'h00; dir = 1'b1;
    tick();
    chk("t5_load1", cnt_c, 1);
    load = 1'b0; en = 1'b1;
    tick();
    chk("t5_low", cnt_c, 1);
    chk("t5_low_tc", tc_c, 1);

    // 6: async reset mid-operation overrides a pending load
    do_reset();
    dir = 1'b0; en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      load = 1'b1; load_val = 8'hFF;
      tick();
      load = 1'b0;
      tick();
    end
    load = 1'b1; load_val = 8'h40;
    tick();
    load = 1'b0;
    chk("t6_pre_count", cnt_a, 8'h41);
    chk("t6_pre_wrap", wr_a, 3);
    load = 1'b1; load_val = 8'h80; reset = 1'b1;
    #1;
    chk("t6_rst_count", cnt_a, 1);
    chk("t6_rst_tc", tc_a, 0);
    chk("t6_rst_wrap", wr_a, 0);
    tick();
    chk("t6_held", cnt_a, 1);
    load = 1'b0; reset = 1'b0;
    tick();
    chk("t6_resume", cnt_a, 3);
    chk("t6_resume_tc", tc_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
